// File: rtl/serdes_pkg.sv
// Shared SERDES test definitions: PRBS31 taps, checker state encoding and statistics widths.
// Pure declarations; no logic, no latency, no flow control.
package serdes_pkg;

    localparam int PRBS31_LEN   = 31;
    localparam int PRBS31_TAP_A = 31;
    localparam int PRBS31_TAP_B = 28;

    localparam int STAT_CNT_W = 32;
    localparam int LOL_CNT_W  = 16;

    typedef enum logic [1:0] {
        ST_SEED   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } chk_state_t;

endpackage

// File: rtl/prbs31_predict.sv
// Combinational PRBS31 (x^31+x^28+1) next-bit predictor and LFSR advance.
// Zero latency; no flow control.
module prbs31_predict
    import serdes_pkg::*;
(
    input  logic [PRBS31_LEN-1:0] lfsr,
    output logic                  pred_bit,
    output logic [PRBS31_LEN-1:0] lfsr_next
);

    always_comb begin
        pred_bit  = lfsr[PRBS31_TAP_A-1] ^ lfsr[PRBS31_TAP_B-1];
        lfsr_next = {lfsr[PRBS31_LEN-2:0], pred_bit};
    end

endmodule

// File: rtl/prbs31_sync_checker.sv
// PRBS31 self-synchronising checker: seed from data, verify, lock, track errors and loss of lock.
// Outputs registered one cycle after each valid bit; idle cycles (data_in_valid=0) stall everything.
module prbs31_sync_checker
    import serdes_pkg::*;
#(
    parameter int LOCK_COUNT     = 64,
    parameter int WINDOW         = 128,
    parameter int LOSS_THRESHOLD = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  data_in,
    input  logic                  data_in_valid,
    input  logic                  clear_counters,
    output logic                  locked,
    output logic                  error_pulse,
    output logic [STAT_CNT_W-1:0] total_bits,
    output logic [STAT_CNT_W-1:0] total_bit_errors,
    output logic [LOL_CNT_W-1:0]  loss_of_lock_count
);

    localparam int SEED_W  = $clog2(PRBS31_LEN);
    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int WIN_W   = $clog2(WINDOW);
    localparam int ERR_W   = $clog2(LOSS_THRESHOLD + 1);

    chk_state_t              state_q, state_d;
    logic [SEED_W-1:0]       seed_cnt_q, seed_cnt_d;
    logic [MATCH_W-1:0]      match_cnt_q, match_cnt_d;
    logic [WIN_W-1:0]        win_bits_q, win_bits_d;
    logic [ERR_W-1:0]        win_errs_q, win_errs_d;
    logic [PRBS31_LEN-1:0]   lfsr_q, lfsr_d;
    logic                    locked_q, locked_d;
    logic                    error_pulse_q, error_pulse_d;
    logic [STAT_CNT_W-1:0]   total_bits_q, total_bits_d;
    logic [STAT_CNT_W-1:0]   total_errs_q, total_errs_d;
    logic [LOL_CNT_W-1:0]    lol_cnt_q, lol_cnt_d;

    logic                    pred_bit;
    logic [PRBS31_LEN-1:0]   lfsr_next;
    logic                    mismatch;
    logic [ERR_W-1:0]        win_errs_inc;

    prbs31_predict u_predict (
        .lfsr      (lfsr_q),
        .pred_bit  (pred_bit),
        .lfsr_next (lfsr_next)
    );

    assign mismatch     = data_in ^ pred_bit;
    assign win_errs_inc = win_errs_q + ERR_W'(mismatch);

    always_comb begin
        state_d       = state_q;
        seed_cnt_d    = seed_cnt_q;
        match_cnt_d   = match_cnt_q;
        win_bits_d    = win_bits_q;
        win_errs_d    = win_errs_q;
        lfsr_d        = lfsr_q;
        error_pulse_d = 1'b0;
        total_bits_d  = total_bits_q;
        total_errs_d  = total_errs_q;
        lol_cnt_d     = lol_cnt_q;

        if (data_in_valid) begin
            unique case (state_q)
                ST_SEED: begin
                    lfsr_d = {lfsr_q[PRBS31_LEN-2:0], data_in};
                    if (seed_cnt_q == SEED_W'(PRBS31_LEN - 1)) begin
                        state_d     = ST_VERIFY;
                        seed_cnt_d  = '0;
                        match_cnt_d = '0;
                    end else begin
                        seed_cnt_d = seed_cnt_q + 1'b1;
                    end
                end
                ST_VERIFY: begin
                    lfsr_d = lfsr_next;
                    if (mismatch) begin
                        error_pulse_d = 1'b1;
                        state_d       = ST_SEED;
                        seed_cnt_d    = '0;
                    end else if (match_cnt_q == MATCH_W'(LOCK_COUNT - 1)) begin
                        state_d    = ST_LOCKED;
                        win_bits_d = '0;
                        win_errs_d = '0;
                    end else begin
                        match_cnt_d = match_cnt_q + 1'b1;
                    end
                end
                ST_LOCKED: begin
                    // Flywheel: once locked the LFSR never re-seeds from line data.
                    lfsr_d        = lfsr_next;
                    error_pulse_d = mismatch;
                    if (!(&total_bits_q)) total_bits_d = total_bits_q + 1'b1;
                    if (mismatch && !(&total_errs_q)) total_errs_d = total_errs_q + 1'b1;
                    win_bits_d = (win_bits_q == WIN_W'(WINDOW - 1)) ? '0 : win_bits_q + 1'b1;
                    if (win_errs_inc >= ERR_W'(LOSS_THRESHOLD)) begin
                        state_d    = ST_SEED;
                        seed_cnt_d = '0;
                        if (!(&lol_cnt_q)) lol_cnt_d = lol_cnt_q + 1'b1;
                    end else if (win_bits_q == WIN_W'(WINDOW - 1)) begin
                        win_errs_d = '0;
                    end else begin
                        win_errs_d = win_errs_inc;
                    end
                end
                default: begin
                    state_d    = ST_SEED;
                    seed_cnt_d = '0;
                end
            endcase
        end

        if (clear_counters) begin
            total_bits_d = '0;
            total_errs_d = '0;
            lol_cnt_d    = '0;
        end

        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q       <= ST_SEED;
            seed_cnt_q    <= '0;
            match_cnt_q   <= '0;
            win_bits_q    <= '0;
            win_errs_q    <= '0;
            lfsr_q        <= '0;
            locked_q      <= 1'b0;
            error_pulse_q <= 1'b0;
            total_bits_q  <= '0;
            total_errs_q  <= '0;
            lol_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            seed_cnt_q    <= seed_cnt_d;
            match_cnt_q   <= match_cnt_d;
            win_bits_q    <= win_bits_d;
            win_errs_q    <= win_errs_d;
            lfsr_q        <= lfsr_d;
            locked_q      <= locked_d;
            error_pulse_q <= error_pulse_d;
            total_bits_q  <= total_bits_d;
            total_errs_q  <= total_errs_d;
            lol_cnt_q     <= lol_cnt_d;
        end
    end

    assign locked             = locked_q;
    assign error_pulse        = error_pulse_q;
    assign total_bits         = total_bits_q;
    assign total_bit_errors   = total_errs_q;
    assign loss_of_lock_count = lol_cnt_q;

endmodule

// File: tb/tb_prbs31_sync_checker.sv
// Bench for prbs31_sync_checker: directed PRBS31 scenarios with a cycle scoreboard plus hand-derived spot checks.
module tb_prbs31_sync_checker;

    localparam int LOCK = 64;
    localparam int WIN  = 128;
    localparam int LOSS = 8;

    typedef struct packed {
        logic        locked;
        logic        err;
        logic [31:0] bits;
        logic [31:0] errs;
        logic [15:0] lol;
    } obs_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        data_in = 1'b0;
    logic        data_in_valid = 1'b0;
    logic        clear_counters = 1'b0;
    logic        locked;
    logic        error_pulse;
    logic [31:0] total_bits;
    logic [31:0] total_bit_errors;
    logic [15:0] loss_of_lock_count;

    int checks = 0;
    int failures = 0;
    int cyc_no = 0;

    obs_t exp_q[$];

    // Reference model state (history queue oldest-first, always 31 entries)
    int          m_state;   // 0 seed, 1 verify, 2 locked
    int          m_seed, m_match, m_wbit, m_werr;
    bit          m_hist[$];
    logic [31:0] m_bits, m_errs;
    logic [15:0] m_lol;
    bit          m_err;

    // Stimulus generator history, oldest-first
    bit g_hist[$];

    prbs31_sync_checker #(
        .LOCK_COUNT     (LOCK),
        .WINDOW         (WIN),
        .LOSS_THRESHOLD (LOSS)
    ) dut (
        .clk                (clk),
        .rstn               (rstn),
        .data_in            (data_in),
        .data_in_valid      (data_in_valid),
        .clear_counters     (clear_counters),
        .locked             (locked),
        .error_pulse        (error_pulse),
        .total_bits         (total_bits),
        .total_bit_errors   (total_bit_errors),
        .loss_of_lock_count (loss_of_lock_count)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic bit gen_bit();
        bit nb;
        nb = g_hist[0] ^ g_hist[3];
        g_hist.push_back(nb);
        void'(g_hist.pop_front());
        return nb;
    endfunction

    task automatic model_reset();
        m_state = 0; m_seed = 0; m_match = 0; m_wbit = 0; m_werr = 0;
        m_hist.delete();
        for (int i = 0; i < 31; i++) m_hist.push_back(1'b0);
        m_bits = '0; m_errs = '0; m_lol = '0; m_err = 1'b0;
    endtask

    task automatic model_step(input bit v, input bit d, input bit clr, input bit rst);
        bit pred, mism;
        int e;
        if (rst) begin
            model_reset();
            return;
        end
        m_err = 1'b0;
        if (v) begin
            if (m_state == 0) begin
                m_hist.push_back(d);
                void'(m_hist.pop_front());
                if (m_seed == 30) begin m_state = 1; m_seed = 0; m_match = 0; end
                else m_seed++;
            end else begin
                pred = m_hist[0] ^ m_hist[3];
                m_hist.push_back(pred);
                void'(m_hist.pop_front());
                mism = (d != pred);
                if (m_state == 1) begin
                    if (mism) begin m_err = 1'b1; m_state = 0; m_seed = 0; end
                    else if (m_match + 1 == LOCK) begin m_state = 2; m_wbit = 0; m_werr = 0; end
                    else m_match++;
                end else begin
                    if (m_bits != 32'hFFFF_FFFF) m_bits++;
                    if (mism) begin
                        m_err = 1'b1;
                        if (m_errs != 32'hFFFF_FFFF) m_errs++;
                    end
                    e = m_werr + (mism ? 1 : 0);
                    if (e >= LOSS) begin
                        m_state = 0; m_seed = 0;
                        if (m_lol != 16'hFFFF) m_lol++;
                    end else if (m_wbit == WIN - 1) m_werr = 0;
                    else m_werr = e;
                    m_wbit = (m_wbit == WIN - 1) ? 0 : m_wbit + 1;
                end
            end
        end
        if (clr) begin m_bits = '0; m_errs = '0; m_lol = '0; end
    endtask

    // One clock of stimulus; the expected post-edge outputs go to the scoreboard.
    task automatic cyc(input bit v, input bit d, input bit clr, input bit rst);
        obs_t e;
        data_in_valid  = v;
        data_in        = d;
        clear_counters = clr;
        rstn           = rst;
        @(posedge clk);
        model_step(v, d, clr, rst);
        e.locked = (m_state == 2);
        e.err    = m_err;
        e.bits   = m_bits;
        e.errs   = m_errs;
        e.lol    = m_lol;
        exp_q.push_back(e);
        #1;
    endtask

    task automatic send(input bit flip, input bit clr);
        bit b;
        b = gen_bit();
        cyc(1'b1, b ^ flip, clr, 1'b0);
    endtask

    task automatic send_n(input int n);
        for (int i = 0; i < n; i++) send(1'b0, 1'b0);
    endtask

    task automatic idle();
        cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Scoreboard monitor: compares DUT outputs against the queued expectation each cycle.
    always @(negedge clk) begin
        obs_t e, a;
        cyc_no++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {locked, error_pulse, total_bits, total_bit_errors, loss_of_lock_count};
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL scoreboard cyc %0d: got locked=%0b err=%0b bits=%0d errs=%0d lol=%0d expected locked=%0b err=%0b bits=%0d errs=%0d lol=%0d",
                         cyc_no, a.locked, a.err, a.bits, a.errs, a.lol,
                         e.locked, e.err, e.bits, e.errs, e.lol);
            end
        end
    end

    initial begin
        for (int i = 0; i < 31; i++) g_hist.push_back(1'((32'h5A5A_1234 >> i) & 1));
        model_reset();

        // Reset state
        do_reset();
        check("reset_locked", {31'd0, locked}, 32'd0);
        check("reset_bits", total_bits, 32'd0);

        // Clean stream: lock on the 95th valid bit
        send_n(94);
        check("lock_bit94", {31'd0, locked}, 32'd0);
        send_n(1);
        check("lock_bit95", {31'd0, locked}, 32'd1);
        check("lock_entry_bits", total_bits, 32'd0);
        send_n(105);
        check("clean_bits", total_bits, 32'd105);
        check("clean_errs", total_bit_errors, 32'd0);

        // Single flip while locked
        send_n(5);
        send(1'b1, 1'b0);
        check("flip_pulse", {31'd0, error_pulse}, 32'd1);
        check("flip_errs", total_bit_errors, 32'd1);
        check("flip_locked", {31'd0, locked}, 32'd1);
        send_n(1);
        check("flip_pulse_clear", {31'd0, error_pulse}, 32'd0);
        send_n(29);
        check("flip_bits", total_bits, 32'd141);

        // Eight flips within one window: loss on the eighth
        for (int i = 0; i < 7; i++) send(1'b1, 1'b0);
        check("seven_flips_locked", {31'd0, locked}, 32'd1);
        send(1'b1, 1'b0);
        check("eight_flips_locked", {31'd0, locked}, 32'd0);
        check("eight_flips_lol", {16'd0, loss_of_lock_count}, 32'd1);
        check("eight_flips_errs", total_bit_errors, 32'd9);
        check("eight_flips_bits", total_bits, 32'd149);
        send_n(94);
        check("relock_bit94", {31'd0, locked}, 32'd0);
        send_n(1);
        check("relock_bit95", {31'd0, locked}, 32'd1);
        check("relock_bits_kept", total_bits, 32'd149);

        // Flip at match count 40 in verify
        do_reset();
        send_n(71);
        send(1'b1, 1'b0);
        check("verify_flip_pulse", {31'd0, error_pulse}, 32'd1);
        send_n(94);
        check("verify_relock_94", {31'd0, locked}, 32'd0);
        send_n(1);
        check("verify_relock_95", {31'd0, locked}, 32'd1);

        // 50% valid duty
        do_reset();
        for (int i = 0; i < 95; i++) begin
            idle();
            send(1'b0, 1'b0);
            if (i == 93) check("duty_bit94", {31'd0, locked}, 32'd0);
        end
        check("duty_bit95", {31'd0, locked}, 32'd1);
        idle();
        check("duty_idle_locked", {31'd0, locked}, 32'd1);
        check("duty_idle_bits", total_bits, 32'd0);

        // Clear coincident with an error, then reset while locked
        send_n(10);
        send(1'b1, 1'b1);
        check("clr_bits", total_bits, 32'd0);
        check("clr_errs", total_bit_errors, 32'd0);
        check("clr_pulse", {31'd0, error_pulse}, 32'd1);
        check("clr_locked", {31'd0, locked}, 32'd1);
        send_n(3);
        check("post_clr_bits", total_bits, 32'd3);
        cyc(1'b1, gen_bit(), 1'b0, 1'b1);
        check("rst_locked", {31'd0, locked}, 32'd0);
        check("rst_bits", total_bits, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prbs31_sync_checker.md
PRBS31_SYNC_CHECKER -- requirements
Module: prbs31_sync_checker

Interface
REQ-001 Parameter LOCK_COUNT, default 64, consecutive error-free bits in VERIFY required to declare lock.
REQ-002 Parameter WINDOW, default 128, bit-window length for loss-of-lock evaluation while LOCKED.
REQ-003 Parameter LOSS_THRESHOLD, default 8, errors within one WINDOW that force loss of lock.
REQ-004 clk  input  1  single clock, all logic rising-edge.
REQ-005 rstn  input  1  reset, synchronous and active-high (asserted when 1); port name kept per codebase naming.
REQ-006 data_in  input  1  recovered binary bit from grey_decode.
REQ-007 data_in_valid  input  1  qualifies data_in; one bit consumed per valid cycle.
REQ-008 clear_counters  input  1  single-cycle pulse zeroing statistics counters.
REQ-009 locked  output  1  high only in LOCKED state.
REQ-010 error_pulse  output  1  one-cycle strobe for each compared bit that mismatches, in VERIFY or LOCKED.
REQ-011 total_bits  output  32  compared bits counted while LOCKED.
REQ-012 total_bit_errors  output  32  mismatches counted while LOCKED.
REQ-013 loss_of_lock_count  output  16  LOCKED->SEED transitions.

Function
REQ-014 PRBS polynomial x^31+x^28+1; predicted bit = lfsr[30] XOR lfsr[27]; LFSR shifts predicted bit in on each compared valid bit.
REQ-015 States SEED, VERIFY, LOCKED; no action on cycles with data_in_valid=0.
REQ-016 SEED: shift data_in into LFSR for 31 valid bits (seed counter 0..30), then enter VERIFY with match counter 0.
REQ-017 VERIFY: compare data_in with predicted bit; match increments match counter; mismatch pulses error_pulse and returns to SEED with seed counter 0.
REQ-018 VERIFY -> LOCKED when match counter reaches LOCK_COUNT on a matching bit; window bit/error counters cleared on entry.
REQ-019 LOCKED: each valid bit increments total_bits; mismatch increments total_bit_errors and window error counter; LFSR always advances with predicted bit, never re-seeded from data_in.
REQ-020 Window bit counter wraps WINDOW-1 -> 0, clearing window error counter at wrap.
REQ-021 LOCKED -> SEED when window error counter reaches LOSS_THRESHOLD; loss_of_lock_count increments same cycle; total counters retained.
REQ-022 Registered outputs: locked, error_pulse and counters update on the clock edge consuming the bit (latency 1 cycle from valid input).
REQ-023 All 32-bit and 16-bit counters saturate at all-ones; no wrap.
REQ-024 clear_counters zeros total_bits, total_bit_errors, loss_of_lock_count; if coincident with a counted bit, clear wins (result 0); FSM and LFSR unaffected.

Reset
REQ-025 On rstn=1 at clock edge: state SEED, seed/match/window counters 0, LFSR 0, locked 0, error_pulse 0, all statistics counters 0.
REQ-026 Reset mid-operation (any state) discards lock immediately next cycle; no partial count increments that cycle.

Structure
REQ-027 Shared package serdes_pkg holds PRBS31 tap constants (31, 28), checker state enum type, and counter width constants.
REQ-028 One sub-module prbs31_predict: combinational next-bit and next-LFSR-state from current LFSR; instantiated once.

Verification
REQ-029 prbs31 output fed directly, continuous valid -> locked rises on valid bit 31+64=95 (registered one cycle later), total_bit_errors stays 0.
REQ-030 Locked, single bit flip injected -> exactly one error_pulse, total_bit_errors=1, locked remains 1.
REQ-031 Locked, 8 flips within one 128-bit window -> locked drops, loss_of_lock_count=1, relock after further 95 clean bits.
REQ-032 Bit flip at match count 40 in VERIFY -> return to SEED, no LOCKED entry before 95 more clean bits.
REQ-033 data_in_valid toggled 50% duty -> lock reached after 95 valid bits regardless of gaps; idle cycles change nothing.
REQ-034 clear_counters pulse coincident with an error while locked -> all counters read 0 next cycle; rstn=1 while LOCKED -> all outputs 0 next cycle.
